// File: rtl/msrv32_fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid handshake with instruction memory and presents one word to the decoder.
module msrv32_fetch_sequencer #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  BOOT_ADDR = 32'h00000000,
   parameter logic [WIDTH-1:0]  NOP_INSTR = 32'h00000013
) (
   input  logic              ms_riscv32_mp_clk_in,
   input  logic              ms_riscv32_mp_rst_in,
   output logic              imem_req_out,
   output logic [WIDTH-1:0]  imem_addr_out,
   input  logic              imem_gnt_in,
   input  logic              imem_rvalid_in,
   input  logic [WIDTH-1:0]  imem_rdata_in,
   input  logic              redirect_in,
   input  logic [WIDTH-1:0]  redirect_pc_in,
   input  logic              stall_in,
   output logic [WIDTH-1:0]  instr_out,
   output logic [WIDTH-1:0]  pc_out,
   output logic              instr_valid_out,
   output logic              flush_out
);

   typedef enum logic [1:0] {
      RST_S   = 2'd0,
      REQ_S   = 2'd1,
      WAIT_S  = 2'd2,
      VALID_S = 2'd3
   } fetch_state_t;

   localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};
   localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'd4};

   fetch_state_t      state, state_nxt;
   logic [WIDTH-1:0]  fetch_pc, fetch_pc_nxt;
   logic              kill, kill_nxt;
   logic [WIDTH-1:0]  instr_nxt, pc_nxt;
   logic              valid_nxt;
   logic [WIDTH-1:0]  redirect_target;

   assign redirect_target = redirect_pc_in & ALIGN_MASK;
   assign imem_addr_out   = fetch_pc;
   assign flush_out       = ~instr_valid_out;
   // Request is suppressed while reset is held so nothing is issued before RST_S is entered.
   assign imem_req_out    = (state == REQ_S) && !ms_riscv32_mp_rst_in;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state           <= RST_S;
         fetch_pc        <= BOOT_ADDR;
         kill            <= 1'b0;
         instr_out       <= NOP_INSTR;
         pc_out          <= BOOT_ADDR;
         instr_valid_out <= 1'b0;
      end else begin
         state           <= state_nxt;
         fetch_pc        <= fetch_pc_nxt;
         kill            <= kill_nxt;
         instr_out       <= instr_nxt;
         pc_out          <= pc_nxt;
         instr_valid_out <= valid_nxt;
      end
   end

   // NOTE: every combinational output gets a hold default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      kill_nxt     = kill;
      instr_nxt    = instr_out;
      pc_nxt       = pc_out;
      valid_nxt    = instr_valid_out;

      unique case (state)
         RST_S: begin
            state_nxt = REQ_S;
         end

         REQ_S: begin
            if (imem_gnt_in) state_nxt = WAIT_S;
            if (redirect_in) begin
               fetch_pc_nxt = redirect_target;
               instr_nxt    = NOP_INSTR;
               valid_nxt    = 1'b0;
               // A granted old-address request is still in flight; its response must be dropped.
               if (imem_gnt_in) kill_nxt = 1'b1;
            end
         end

         WAIT_S: begin
            if (redirect_in) begin
               fetch_pc_nxt = redirect_target;
               instr_nxt    = NOP_INSTR;
               valid_nxt    = 1'b0;
               if (imem_rvalid_in) begin
                  kill_nxt  = 1'b0;
                  state_nxt = REQ_S;
               end else begin
                  kill_nxt  = 1'b1;
               end
            end else if (imem_rvalid_in) begin
               if (kill) begin
                  kill_nxt  = 1'b0;
                  state_nxt = REQ_S;
               end else begin
                  instr_nxt    = imem_rdata_in;
                  pc_nxt       = fetch_pc;
                  valid_nxt    = 1'b1;
                  fetch_pc_nxt = fetch_pc + PC_STEP;
                  state_nxt    = VALID_S;
               end
            end
         end

         VALID_S: begin
            if (redirect_in) begin
               fetch_pc_nxt = redirect_target;
               instr_nxt    = NOP_INSTR;
               valid_nxt    = 1'b0;
               state_nxt    = REQ_S;
            end else if (!stall_in) begin
               instr_nxt = NOP_INSTR;
               valid_nxt = 1'b0;
               state_nxt = REQ_S;
            end
         end

         default: state_nxt = RST_S;
      endcase
   end

endmodule

// File: tb/tb_msrv32_fetch_sequencer.sv
// Directed self-checking bench for msrv32_fetch_sequencer: handshake, stall,
// redirect/kill, PC wrap and mid-transaction reset.
module tb_msrv32_fetch_sequencer;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        flush;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   msrv32_fetch_sequencer dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .imem_req_out         (imem_req),
      .imem_addr_out        (imem_addr),
      .imem_gnt_in          (imem_gnt),
      .imem_rvalid_in       (imem_rvalid),
      .imem_rdata_in        (imem_rdata),
      .redirect_in          (redirect),
      .redirect_pc_in       (redirect_pc),
      .stall_in             (stall),
      .instr_out            (instr),
      .pc_out               (pc),
      .instr_valid_out      (instr_valid),
      .flush_out            (flush)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 ns after the edge, well away from sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_idle_out(input string tag);
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_flush"}, {31'd0, flush}, 32'd1);
      check({tag, "_instr"}, instr, NOP);
   endtask

   task automatic expect_req(input string tag, input logic [31:0] addr);
      check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      check({tag, "_addr"}, imem_addr, addr);
   endtask

   task automatic expect_live(input string tag, input logic [31:0] word, input logic [31:0] wpc);
      check({tag, "_instr"}, instr, word);
      check({tag, "_pc"}, pc, wpc);
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      check({tag, "_flush"}, {31'd0, flush}, 32'd0);
      check({tag, "_noreq"}, {31'd0, imem_req}, 32'd0);
   endtask

   // From REQ_S: immediate grant then immediate response, ending in VALID_S.
   task automatic fetch_now(input logic [31:0] word);
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      tick();
      imem_rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
      tick(); tick();

      // Reset state
      expect_idle_out("rst");
      check("rst_pc", pc, 32'h0);
      check("rst_req", {31'd0, imem_req}, 32'd0);

      rst = 1'b0;
      check("rst_s_noreq", {31'd0, imem_req}, 32'd0);
      tick();
      expect_req("boot", 32'h0);

      // First fetch, then 4-cycle stall in VALID_S
      fetch_now(32'h00500093);
      expect_live("f0", 32'h00500093, 32'h0);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_live("stall", 32'h00500093, 32'h0);
      end
      stall = 1'b0;
      tick();
      expect_idle_out("consume");
      expect_req("next", 32'h4);

      // Redirect in WAIT_S, response two cycles later is discarded
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h00000103;
      tick();
      redirect = 1'b0;
      check("wr_noreq", {31'd0, imem_req}, 32'd0);
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
      tick();
      imem_rvalid = 1'b0;
      expect_idle_out("wr_drop");
      expect_req("wr_target", 32'h100);
      fetch_now(32'h00A00113);
      expect_live("f100", 32'h00A00113, 32'h100);
      tick();
      expect_req("after100", 32'h104);

      // Redirect coinciding with grant: kill the in-flight response
      imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000200;
      tick();
      imem_gnt = 1'b0; redirect = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
      tick();
      imem_rvalid = 1'b0;
      expect_idle_out("kill");
      expect_req("kill_target", 32'h200);

      // Stray rvalid in REQ_S is ignored
      imem_rvalid = 1'b1; imem_rdata = 32'h55555555;
      tick();
      imem_rvalid = 1'b0;
      expect_idle_out("stray");
      expect_req("stray", 32'h200);

      // Redirect before grant changes the address; PC wraps past 0xFFFFFFFC
      redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      tick();
      redirect = 1'b0;
      expect_req("wrap_req", 32'hFFFFFFFC);
      fetch_now(32'h22222222);
      expect_live("wrap", 32'h22222222, 32'hFFFFFFFC);
      tick();
      expect_req("wrap_next", 32'h0);

      // Redirect in VALID_S while stalled drops the held instruction
      fetch_now(32'h33333333);
      expect_live("f0b", 32'h33333333, 32'h0);
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000042;
      tick();
      stall = 1'b0; redirect = 1'b0;
      expect_idle_out("vr");
      expect_req("vr_target", 32'h40);
      fetch_now(32'h44444444);
      expect_live("f40", 32'h44444444, 32'h40);
      tick();
      expect_req("after40", 32'h44);

      // Reset asserted in WAIT_S
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      rst = 1'b1;
      tick();
      expect_idle_out("mrst");
      check("mrst_pc", pc, 32'h0);
      check("mrst_noreq", {31'd0, imem_req}, 32'd0);
      rst = 1'b0;
      check("mrst_rst_s", {31'd0, imem_req}, 32'd0);
      tick();
      expect_req("mrst_boot", 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/msrv32_fetch_sequencer.md
Name: msrv32_fetch_sequencer

Overview:
- Sequences instruction fetch for the RV32I core: owns the fetch PC and runs a single-outstanding request/grant/response handshake with instruction memory.
- Holds the fetched word and its PC for the instruction decoder.
- Drives the decoder's flush input, so the decoder substitutes a NOP (32'h00000013) whenever no valid instruction is presented.
- Sits between instruction memory and the decoder; takes PC redirects (branch/jump/trap) and a stall from downstream.

Parameters:
- WIDTH, 32, data/address width.
- BOOT_ADDR, 32'h00000000, fetch PC loaded at reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h00000013, value held on instr_out while invalid.

Ports:
- ms_riscv32_mp_clk_in  input  1  clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  WIDTH  fetch address; equals fetch_pc.
- imem_gnt_in  input  1  request accepted this cycle.
- imem_rvalid_in  input  1  response data valid.
- imem_rdata_in  input  WIDTH  response instruction word.
- redirect_in  input  1  load a new fetch PC.
- redirect_pc_in  input  WIDTH  redirect target; bits [1:0] are forced to 0 internally.
- stall_in  input  1  downstream not ready to consume.
- instr_out  output  WIDTH  registered instruction to the decoder.
- pc_out  output  WIDTH  registered PC of instr_out.
- instr_valid_out  output  1  instr_out/pc_out hold a live instruction.
- flush_out  output  1  to decoder flush input; equals ~instr_valid_out (combinational from registers).

Behaviour:
- States: RST_S, REQ_S, WAIT_S, VALID_S. Internal registers: fetch_pc, kill flag.
- Reset (synchronous, wins over everything):
  - state=RST_S, fetch_pc=BOOT_ADDR, kill=0.
  - instr_out=NOP_INSTR, pc_out=BOOT_ADDR, instr_valid_out=0, so flush_out=1.
  - imem_req_out=0.
- RST_S: imem_req_out=0; unconditionally goes to REQ_S next cycle. A redirect in RST_S is ignored.
- REQ_S:
  - imem_req_out=1, imem_addr_out=fetch_pc.
  - gnt=1: go to WAIT_S.
  - gnt=0: stay in REQ_S with req and address held.
- WAIT_S:
  - imem_req_out=0.
  - rvalid=1 with kill=0: instr_out<=rdata, pc_out<=fetch_pc, instr_valid_out<=1, fetch_pc<=fetch_pc+4, go to VALID_S.
  - rvalid=1 with kill=1: discard data, clear kill, go to REQ_S.
  - rvalid=0: stay in WAIT_S.
- VALID_S:
  - imem_req_out=0.
  - stall_in=1: hold all outputs.
  - stall_in=0: the instruction is consumed this cycle. Next cycle instr_valid_out=0, instr_out=NOP_INSTR; go to REQ_S.
- Redirect (any state except RST_S) takes priority over the normal fetch_pc update:
  - fetch_pc<=redirect_pc_in & ~3; next cycle instr_valid_out=0, instr_out=NOP_INSTR.
  - REQ_S, gnt=0: stay in REQ_S; the new address appears next cycle. Changing the address before grant is legal on this bus.
  - REQ_S, gnt=1: the old-address request is outstanding; go to WAIT_S with kill=1.
  - WAIT_S, rvalid=0: kill<=1, stay in WAIT_S.
  - WAIT_S, rvalid=1: drop the data, kill<=0, go to REQ_S.
  - VALID_S: drop the held instruction regardless of stall_in; go to REQ_S.
- Throughput: when gnt and rvalid each arrive on the first eligible cycle and there is no stall, one instruction per 3 cycles (REQ, WAIT, VALID).
- Arithmetic: fetch_pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
- Outstanding requests: never more than one; imem_req_out is never high in WAIT_S or VALID_S.
- Unexpected response: imem_rvalid_in outside WAIT_S is ignored.
- Reset mid-transaction: state returns to RST_S. A late rvalid arriving in RST_S or REQ_S after reset is ignored. The memory must not return data for a pre-reset request after issuing a grant to a post-reset request.

Test Plan:
- Reset release, gnt and rvalid immediate, rdata=32'h00500093 -> addr 0x0 requested; cycle 3: instr_out=32'h00500093, pc_out=0, valid=1, flush_out=0; next request addr=0x4.
- stall_in high for 4 cycles in VALID_S -> instr_out/pc_out/valid stable for 4 cycles, no imem_req_out; after stall drops, request addr 0x4.
- redirect_in with redirect_pc_in=32'h00000103 in WAIT_S, rvalid 2 cycles later -> that response discarded, flush_out stays 1, next request addr=0x100.
- redirect in REQ_S in the same cycle as gnt -> kill set; first rvalid dropped; next request addr=redirect target.
- Redirect to 32'hFFFFFFFC, fetch completes -> pc_out=32'hFFFFFFFC, next imem_addr_out=0x0.
- Reset asserted in WAIT_S -> next cycle valid=0, instr_out=32'h00000013, pc_out=BOOT_ADDR, req low for 1 cycle then request BOOT_ADDR.
